// File: rtl/gray_bin_pipe_if.sv
// Handshake bundle for gray_bin_pipe: upstream valid/ready with din/mode, downstream valid/ready with dout/out_mode.
// adj_err exists only when GRAY_BIN_ADJ_CHECK_EN is defined.
interface gray_bin_pipe_if #(parameter int WIDTH = 6);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             out_mode;
`ifdef GRAY_BIN_ADJ_CHECK_EN
  logic             adj_err;

  modport master (output in_valid, mode, din, out_ready,
                  input  in_ready, out_valid, dout, out_mode, adj_err);
  modport slave  (input  in_valid, mode, din, out_ready,
                  output in_ready, out_valid, dout, out_mode, adj_err);
`else
  modport master (output in_valid, mode, din, out_ready,
                  input  in_ready, out_valid, dout, out_mode);
  modport slave  (input  in_valid, mode, din, out_ready,
                  output in_ready, out_valid, dout, out_mode);
`endif
endinterface

// File: rtl/gray_bin_pipe.sv
// Two-stage elastic Gray<->binary converter; mode 0 = gray-to-binary, 1 = binary-to-gray.
// Optional Gray adjacency checker enabled by macro GRAY_BIN_ADJ_CHECK_EN.
module gray_bin_pipe #(
  parameter int WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_bin_pipe_if.slave bus
);

  logic             s1_valid;
  logic             s1_mode;
  logic [WIDTH-1:0] s1_data;
  logic             s2_valid;
  logic             s2_mode;
  logic [WIDTH-1:0] s2_data;
  logic             s2_adv;
  logic [WIDTH-1:0] conv;

  // S2 frees up when empty or draining; S1 moves into S2 on the same condition.
  assign s2_adv      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;

  // NOTE: every variable assigned in always_comb gets a value on all paths, otherwise a latch is inferred.
  always_comb begin
    conv = s1_data ^ (s1_data >> 1);
    if (!s1_mode) begin
      conv[WIDTH-1] = s1_data[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
        conv[i] = conv[i+1] ^ s1_data[i];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_mode <= bus.mode;
    end
  end

  // NOTE: S1 payload is deliberately left out of reset; s1_valid qualifies it.
  always_ff @(posedge clk) begin
    if (bus.in_ready && bus.in_valid) s1_data <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_mode  <= 1'b0;
      s2_data  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mode <= s1_mode;
        s2_data <= conv;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.dout      = s2_data;
  assign bus.out_mode  = s2_mode;

`ifdef GRAY_BIN_ADJ_CHECK_EN
  logic [WIDTH-1:0] gray_val;
  logic [WIDTH-1:0] hist;
  logic             hist_valid;
  logic             s2_adj;
  logic             adj_next;

  // The gray-domain value is the input for gray-to-binary, the result for binary-to-gray.
  assign gray_val = s1_mode ? conv : s1_data;
  assign adj_next = hist_valid && ($countones(gray_val ^ hist) != 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_valid <= 1'b0;
      hist       <= '0;
      s2_adj     <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      hist_valid <= 1'b1;
      hist       <= gray_val;
      s2_adj     <= adj_next;
    end
  end

  assign bus.adj_err = s2_adj;
`endif

endmodule

// File: tb/tb_gray_bin_pipe.sv
// Randomized self-checking bench for gray_bin_pipe with a queue-based scoreboard; WIDTH = 6.
// Adjacency checks are compiled in when GRAY_BIN_ADJ_CHECK_EN is defined.
module tb_gray_bin_pipe;
  localparam int W = 6;

  typedef struct {
    logic [W-1:0] data;
    logic         mode;
    logic         adj;
    int           cyc;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  word_t        q[$];
  logic [W-1:0] hist;
  logic         hist_v;

  gray_bin_pipe_if #(.WIDTH(W)) bus ();
  gray_bin_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_conv(input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    if (m) return d ^ (d >> 1);
    for (int i = 0; i < W; i++) r[i] = ^(d >> i);
    return r;
  endfunction

  function automatic word_t make_word(input logic [W-1:0] d, input logic m, input int c);
    word_t        w;
    logic [W-1:0] g;
    w.data = ref_conv(d, m);
    w.mode = m;
    w.cyc  = c;
    g      = m ? w.data : d;
    w.adj  = hist_v ? ($countones(g ^ hist) != 1) : 1'b0;
    hist   = g;
    hist_v = 1'b1;
    return w;
  endfunction

  // One clock cycle: drive at negedge, check against the scoreboard, update it.
  task automatic step(input logic iv, input logic m, input logic [W-1:0] d, input logic ordy);
    logic exp_ov;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.mode      = m;
    bus.din       = d;
    bus.out_ready = ordy;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || ordy));
    exp_ov = (q.size() > 0) && (cyc >= q[0].cyc + 2);
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (exp_ov && bus.out_valid) begin
      check("dout", 32'(bus.dout), 32'(q[0].data));
      check("out_mode", 32'(bus.out_mode), 32'(q[0].mode));
`ifdef GRAY_BIN_ADJ_CHECK_EN
      check("adj_err", 32'(bus.adj_err), 32'(q[0].adj));
`endif
      if (ordy) void'(q.pop_front());
    end
    if (iv && bus.in_ready) q.push_back(make_word(d, m, cyc));
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_out_mode", 32'(bus.out_mode), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef GRAY_BIN_ADJ_CHECK_EN
    check("rst_adj_err", 32'(bus.adj_err), 32'd0);
`endif
    rst_n = 1'b1;
    q.delete();
    hist_v = 1'b0;
    hist   = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 1'b0, '0, 1'b1);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.din       = '0;
    bus.out_ready = 1'b1;
    hist_v        = 1'b0;
    hist          = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Known conversions, back-to-back with interleaved modes.
    step(1'b1, 1'b0, 6'b111011, 1'b1);
    step(1'b1, 1'b1, 6'b101101, 1'b1);
    #1 check("g2b_111011", 32'(bus.dout), 32'(6'b101101));
    check("g2b_mode", 32'(bus.out_mode), 32'd0);
    step(1'b1, 1'b0, 6'b100101, 1'b1);
    #1 check("b2g_101101", 32'(bus.dout), 32'(6'b111011));
    check("b2g_mode", 32'(bus.out_mode), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    #1 check("g2b_100101", 32'(bus.dout), 32'(6'b111001));
    drain();

    // Adjacency stream after a fresh reset: expected flags 0, 0, 1.
    do_reset();
    step(1'b1, 1'b0, 6'b111011, 1'b1);
    step(1'b1, 1'b0, 6'b111111, 1'b1);
`ifdef GRAY_BIN_ADJ_CHECK_EN
    #1 check("adj_first", 32'(bus.adj_err), 32'd0);
`endif
    step(1'b1, 1'b0, 6'b100101, 1'b1);
`ifdef GRAY_BIN_ADJ_CHECK_EN
    #1 check("adj_one_bit", 32'(bus.adj_err), 32'd0);
`endif
    step(1'b0, 1'b0, '0, 1'b1);
`ifdef GRAY_BIN_ADJ_CHECK_EN
    #1 check("adj_three_bit", 32'(bus.adj_err), 32'd1);
`endif
    drain();

    // Backpressure: four stalled cycles accept exactly two words.
    for (int i = 0; i < 4; i++) step(1'b1, i[0], 6'(i * 13 + 5), 1'b0);
    check("bp_accepted", 32'(q.size()), 32'd2);
    drain();

    // Reset with two words in flight; first word afterwards has a clean history.
    step(1'b1, 1'b0, 6'b010101, 1'b0);
    step(1'b1, 1'b1, 6'b001100, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 6'b000111, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
`ifdef GRAY_BIN_ADJ_CHECK_EN
    #1 check("adj_after_reset", 32'(bus.adj_err), 32'd0);
`endif
    drain();

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'($urandom_range(0, 3) != 0), 1'($urandom), 6'($urandom),
                1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
